// File: rtl/scarv_cop_vtx_tracer.sv
// rtl/scarv_cop_vtx_tracer.sv - per-instruction trace record producer for COP checkers
module scarv_cop_vtx_tracer #(
    parameter int MEM_SLOTS = 4
) (
    input  logic                      g_clk,
    input  logic                      g_resetn,
    input  logic                      cpu_insn_req,
    input  logic                      cop_insn_ack,
    input  logic [31:0]               cpu_insn_enc,
    input  logic [31:0]               cpu_rs1,
    input  logic                      cop_insn_rsp,
    input  logic                      cpu_insn_ack,
    input  logic [2:0]                cop_result,
    input  logic                      cop_wen,
    input  logic [4:0]                cop_waddr,
    input  logic [31:0]               cop_wdata,
    input  logic [511:0]              cop_cprs,
    input  logic                      cop_mem_cen,
    input  logic                      cop_mem_wen,
    input  logic [31:0]               cop_mem_addr,
    input  logic [31:0]               cop_mem_wdata,
    input  logic [3:0]                cop_mem_ben,
    input  logic [31:0]               cop_mem_rdata,
    input  logic                      cop_mem_stall,
    input  logic                      cop_mem_error,
    input  logic [31:0]               rng_sample,
    output logic                      vtx_valid,
    output logic                      vtx_reset,
    output logic                      vtx_cpu_req,
    output logic                      vtx_cop_ack,
    output logic                      vtx_cop_rsp,
    output logic                      vtx_cpu_ack,
    output logic [31:0]               vtx_instr_enc,
    output logic [31:0]               vtx_instr_rs1,
    output logic [2:0]                vtx_instr_result,
    output logic                      vtx_instr_wen,
    output logic [4:0]                vtx_instr_waddr,
    output logic [31:0]               vtx_instr_wdata,
    output logic [31:0]               vtx_rand_sample,
    output logic [511:0]              vtx_cprs_pre,
    output logic [511:0]              vtx_cprs_post,
    output logic [MEM_SLOTS-1:0]      vtx_mem_cen,
    output logic [MEM_SLOTS-1:0]      vtx_mem_wen,
    output logic [MEM_SLOTS-1:0]      vtx_mem_error,
    output logic [32*MEM_SLOTS-1:0]   vtx_mem_addr,
    output logic [32*MEM_SLOTS-1:0]   vtx_mem_wdata,
    output logic [32*MEM_SLOTS-1:0]   vtx_mem_rdata,
    output logic [4*MEM_SLOTS-1:0]    vtx_mem_ben,
    output logic                      vtx_mem_ovf
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, POST = 2'd2} state_t;

    localparam logic [2:0] SLOTS_FULL = 3'(MEM_SLOTS);

    state_t state, state_nxt;
    logic   accept, retire, txn;
    logic   start, rec_txn, cap_ret, publish;

    logic [31:0]             w_enc, w_rs1, w_rng, w_wdata;
    logic [2:0]              w_result;
    logic                    w_wen;
    logic [4:0]              w_waddr;
    logic [511:0]            w_pre;
    logic [2:0]              w_cnt;
    logic                    w_ovf;
    logic [MEM_SLOTS-1:0]    w_mem_cen, w_mem_wen, w_mem_error;
    logic [32*MEM_SLOTS-1:0] w_mem_addr, w_mem_wdata, w_mem_rdata;
    logic [4*MEM_SLOTS-1:0]  w_mem_ben;
    logic [1:0]              slot;

    assign accept = cpu_insn_req & cop_insn_ack;
    assign retire = cop_insn_rsp & cpu_insn_ack;
    assign txn    = cop_mem_cen & ~cop_mem_stall;
    assign slot   = w_cnt[1:0];

    // State register
    always_ff @(posedge g_clk) begin
        if (!g_resetn) state <= IDLE;
        else           state <= state_nxt;
    end

    // Next-state: accepts in BUSY are protocol violations and are ignored
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (retire) state_nxt = POST;
            POST:    state_nxt = accept ? BUSY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control strobes decoded from the current state
    always_comb begin
        start   = 1'b0;
        rec_txn = 1'b0;
        cap_ret = 1'b0;
        publish = 1'b0;
        case (state)
            IDLE: start = accept;
            BUSY: begin
                rec_txn = txn;
                cap_ret = retire;
            end
            POST: begin
                start   = accept;
                publish = 1'b1;
            end
            default: ;
        endcase
    end

    // Working record: built up while the instruction is in flight
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            w_enc <= '0; w_rs1 <= '0; w_rng <= '0; w_pre <= '0;
            w_result <= '0; w_wen <= 1'b0; w_waddr <= '0; w_wdata <= '0;
            w_cnt <= '0; w_ovf <= 1'b0;
            w_mem_cen <= '0; w_mem_wen <= '0; w_mem_error <= '0;
            w_mem_addr <= '0; w_mem_wdata <= '0; w_mem_rdata <= '0; w_mem_ben <= '0;
        end else begin
            if (start) begin
                w_enc     <= cpu_insn_enc;
                w_rs1     <= cpu_rs1;
                w_rng     <= rng_sample;
                w_pre     <= cop_cprs;
                w_cnt     <= '0;
                w_ovf     <= 1'b0;
                w_mem_cen <= '0;
            end
            if (rec_txn) begin
                if (w_cnt != SLOTS_FULL) begin
                    w_mem_cen[slot]              <= 1'b1;
                    w_mem_wen[slot]              <= cop_mem_wen;
                    w_mem_error[slot]            <= cop_mem_error;
                    w_mem_addr[{slot, 5'd0} +: 32]  <= cop_mem_addr;
                    w_mem_wdata[{slot, 5'd0} +: 32] <= cop_mem_wdata;
                    w_mem_rdata[{slot, 5'd0} +: 32] <= cop_mem_rdata;
                    w_mem_ben[{slot, 2'd0} +: 4]    <= cop_mem_ben;
                    w_cnt                        <= w_cnt + 3'd1;
                end else begin
                    w_ovf <= 1'b1;
                end
            end
            if (cap_ret) begin
                w_result <= cop_result;
                w_wen    <= cop_wen;
                w_waddr  <= cop_waddr;
                w_wdata  <= cop_wdata;
            end
        end
    end

    // Published record: loaded in POST, held until the next strobe
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            vtx_valid <= 1'b0;
            vtx_instr_enc <= '0; vtx_instr_rs1 <= '0; vtx_instr_result <= '0;
            vtx_instr_wen <= 1'b0; vtx_instr_waddr <= '0; vtx_instr_wdata <= '0;
            vtx_rand_sample <= '0; vtx_cprs_pre <= '0; vtx_cprs_post <= '0;
            vtx_mem_cen <= '0; vtx_mem_wen <= '0; vtx_mem_error <= '0;
            vtx_mem_addr <= '0; vtx_mem_wdata <= '0; vtx_mem_rdata <= '0;
            vtx_mem_ben <= '0; vtx_mem_ovf <= 1'b0;
        end else begin
            vtx_valid <= publish;
            if (publish) begin
                vtx_instr_enc    <= w_enc;
                vtx_instr_rs1    <= w_rs1;
                vtx_instr_result <= w_result;
                vtx_instr_wen    <= w_wen;
                vtx_instr_waddr  <= w_waddr;
                vtx_instr_wdata  <= w_wdata;
                vtx_rand_sample  <= w_rng;
                vtx_cprs_pre     <= w_pre;
                vtx_cprs_post    <= cop_cprs;
                vtx_mem_cen      <= w_mem_cen;
                vtx_mem_wen      <= w_mem_wen;
                vtx_mem_error    <= w_mem_error;
                vtx_mem_addr     <= w_mem_addr;
                vtx_mem_wdata    <= w_mem_wdata;
                vtx_mem_rdata    <= w_mem_rdata;
                vtx_mem_ben      <= w_mem_ben;
                vtx_mem_ovf      <= w_ovf;
            end
        end
    end

    // Reset flag and one-cycle delayed handshake lines
    always_ff @(posedge g_clk) begin
        vtx_reset <= ~g_resetn;
        if (!g_resetn) begin
            vtx_cpu_req <= 1'b0; vtx_cop_ack <= 1'b0;
            vtx_cop_rsp <= 1'b0; vtx_cpu_ack <= 1'b0;
        end else begin
            vtx_cpu_req <= cpu_insn_req; vtx_cop_ack <= cop_insn_ack;
            vtx_cop_rsp <= cop_insn_rsp; vtx_cpu_ack <= cpu_insn_ack;
        end
    end
endmodule

// File: tb/tb_scarv_cop_vtx_tracer.sv
// tb/tb_scarv_cop_vtx_tracer.sv - directed self-checking bench for scarv_cop_vtx_tracer
module tb_scarv_cop_vtx_tracer;
    logic g_clk = 1'b0;
    logic g_resetn = 1'b0;
    logic cpu_insn_req = 0, cop_insn_ack = 0, cop_insn_rsp = 0, cpu_insn_ack = 0;
    logic [31:0] cpu_insn_enc = 0, cpu_rs1 = 0, cop_wdata = 0, rng_sample = 0;
    logic [2:0] cop_result = 0;
    logic cop_wen = 0;
    logic [4:0] cop_waddr = 0;
    logic [511:0] cop_cprs = '0;
    logic cop_mem_cen = 0, cop_mem_wen = 0, cop_mem_stall = 0, cop_mem_error = 0;
    logic [31:0] cop_mem_addr = 0, cop_mem_wdata = 0, cop_mem_rdata = 0;
    logic [3:0] cop_mem_ben = 0;

    logic vtx_valid, vtx_reset, vtx_cpu_req, vtx_cop_ack, vtx_cop_rsp, vtx_cpu_ack;
    logic [31:0] vtx_instr_enc, vtx_instr_rs1, vtx_instr_wdata, vtx_rand_sample;
    logic [2:0] vtx_instr_result;
    logic vtx_instr_wen;
    logic [4:0] vtx_instr_waddr;
    logic [511:0] vtx_cprs_pre, vtx_cprs_post;
    logic [3:0] vtx_mem_cen, vtx_mem_wen, vtx_mem_error;
    logic [127:0] vtx_mem_addr, vtx_mem_wdata, vtx_mem_rdata;
    logic [15:0] vtx_mem_ben;
    logic vtx_mem_ovf;

    int cmp_count = 0;
    int err_count = 0;
    logic [511:0] exp_cprs;

    scarv_cop_vtx_tracer #(.MEM_SLOTS(4)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .cpu_insn_req(cpu_insn_req), .cop_insn_ack(cop_insn_ack),
        .cpu_insn_enc(cpu_insn_enc), .cpu_rs1(cpu_rs1),
        .cop_insn_rsp(cop_insn_rsp), .cpu_insn_ack(cpu_insn_ack),
        .cop_result(cop_result), .cop_wen(cop_wen), .cop_waddr(cop_waddr), .cop_wdata(cop_wdata),
        .cop_cprs(cop_cprs),
        .cop_mem_cen(cop_mem_cen), .cop_mem_wen(cop_mem_wen), .cop_mem_addr(cop_mem_addr),
        .cop_mem_wdata(cop_mem_wdata), .cop_mem_ben(cop_mem_ben), .cop_mem_rdata(cop_mem_rdata),
        .cop_mem_stall(cop_mem_stall), .cop_mem_error(cop_mem_error),
        .rng_sample(rng_sample),
        .vtx_valid(vtx_valid), .vtx_reset(vtx_reset),
        .vtx_cpu_req(vtx_cpu_req), .vtx_cop_ack(vtx_cop_ack),
        .vtx_cop_rsp(vtx_cop_rsp), .vtx_cpu_ack(vtx_cpu_ack),
        .vtx_instr_enc(vtx_instr_enc), .vtx_instr_rs1(vtx_instr_rs1),
        .vtx_instr_result(vtx_instr_result), .vtx_instr_wen(vtx_instr_wen),
        .vtx_instr_waddr(vtx_instr_waddr), .vtx_instr_wdata(vtx_instr_wdata),
        .vtx_rand_sample(vtx_rand_sample),
        .vtx_cprs_pre(vtx_cprs_pre), .vtx_cprs_post(vtx_cprs_post),
        .vtx_mem_cen(vtx_mem_cen), .vtx_mem_wen(vtx_mem_wen), .vtx_mem_error(vtx_mem_error),
        .vtx_mem_addr(vtx_mem_addr), .vtx_mem_wdata(vtx_mem_wdata), .vtx_mem_rdata(vtx_mem_rdata),
        .vtx_mem_ben(vtx_mem_ben), .vtx_mem_ovf(vtx_mem_ovf)
    );

    always #5 g_clk = ~g_clk;

    task automatic step;
        @(posedge g_clk);
        #1;
    endtask

    task automatic do_accept(input logic [31:0] enc, input logic [31:0] rs1, input logic [31:0] rng);
        cpu_insn_req = 1; cop_insn_ack = 1; cpu_insn_enc = enc; cpu_rs1 = rs1; rng_sample = rng;
        step;
        cpu_insn_req = 0; cop_insn_ack = 0; rng_sample = 32'hFFFF_FFFF;
    endtask

    task automatic do_retire(input logic [2:0] res, input logic wen, input logic [4:0] waddr, input logic [31:0] wdata);
        cop_insn_rsp = 1; cpu_insn_ack = 1; cop_result = res; cop_wen = wen; cop_waddr = waddr; cop_wdata = wdata;
        step;
        cop_insn_rsp = 0; cpu_insn_ack = 0; cop_result = 3'd7; cop_wen = 0; cop_waddr = 5'd31; cop_wdata = 32'hEEEE_EEEE;
    endtask

    task automatic do_txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] ben, input logic [31:0] rdata, input logic err, input int stalls);
        cop_mem_cen = 1; cop_mem_wen = wen; cop_mem_addr = addr; cop_mem_wdata = wdata; cop_mem_ben = ben;
        for (int i = 0; i < stalls; i++) begin
            cop_mem_stall = 1; cop_mem_rdata = 32'hBAD0_BAD0; cop_mem_error = 1;
            step;
        end
        cop_mem_stall = 0; cop_mem_rdata = rdata; cop_mem_error = err;
        step;
        cop_mem_cen = 0; cop_mem_error = 0; cop_mem_rdata = 32'h5555_5555;
    endtask

    task automatic test_reset;
        g_resetn = 0; cpu_insn_req = 1; cop_insn_ack = 1;
        step; step;
        cmp_count++; if (vtx_reset !== 1'b1) begin err_count++; $display("FAIL rst_vtx_reset: got %0h want 1", vtx_reset); end
        cmp_count++; if (vtx_valid !== 1'b0) begin err_count++; $display("FAIL rst_valid: got %0h want 0", vtx_valid); end
        cmp_count++; if (vtx_cpu_req !== 1'b0) begin err_count++; $display("FAIL rst_cpu_req: got %0h want 0", vtx_cpu_req); end
        cmp_count++; if (vtx_mem_cen !== 4'h0) begin err_count++; $display("FAIL rst_mem_cen: got %0h want 0", vtx_mem_cen); end
        cmp_count++; if (vtx_instr_enc !== 32'h0) begin err_count++; $display("FAIL rst_enc: got %0h want 0", vtx_instr_enc); end
        g_resetn = 1; cpu_insn_req = 0; cop_insn_ack = 0;
        step;
        cmp_count++; if (vtx_reset !== 1'b0) begin err_count++; $display("FAIL rst_release: got %0h want 0", vtx_reset); end
        cpu_insn_req = 1;
        step;
        cmp_count++; if (vtx_cpu_req !== 1'b1) begin err_count++; $display("FAIL dly_cpu_req: got %0h want 1", vtx_cpu_req); end
        cmp_count++; if (vtx_cop_ack !== 1'b0) begin err_count++; $display("FAIL dly_cop_ack: got %0h want 0", vtx_cop_ack); end
        cpu_insn_req = 0;
        step;
    endtask

    task automatic test_basic;
        cop_cprs = '0; cop_cprs[0 +: 32] = 32'hDEAD;
        do_accept(32'h0000_1234, 32'd5, 32'hCAFE_F00D);
        step; step;
        cop_cprs[96 +: 32] = 32'd9;
        do_retire(3'd0, 1'b1, 5'd7, 32'hA5);
        cmp_count++; if (vtx_valid !== 1'b0) begin err_count++; $display("FAIL basic_early_valid: got %0h want 0", vtx_valid); end
        cmp_count++; if (vtx_cop_rsp !== 1'b1) begin err_count++; $display("FAIL basic_dly_rsp: got %0h want 1", vtx_cop_rsp); end
        step;
        cmp_count++; if (vtx_valid !== 1'b1) begin err_count++; $display("FAIL basic_valid: got %0h want 1", vtx_valid); end
        cmp_count++; if (vtx_instr_enc !== 32'h1234) begin err_count++; $display("FAIL basic_enc: got %0h want 1234", vtx_instr_enc); end
        cmp_count++; if (vtx_instr_rs1 !== 32'd5) begin err_count++; $display("FAIL basic_rs1: got %0h want 5", vtx_instr_rs1); end
        cmp_count++; if (vtx_rand_sample !== 32'hCAFE_F00D) begin err_count++; $display("FAIL basic_rng: got %0h want cafef00d", vtx_rand_sample); end
        cmp_count++; if (vtx_instr_result !== 3'd0) begin err_count++; $display("FAIL basic_result: got %0h want 0", vtx_instr_result); end
        cmp_count++; if (vtx_instr_wen !== 1'b1) begin err_count++; $display("FAIL basic_wen: got %0h want 1", vtx_instr_wen); end
        cmp_count++; if (vtx_instr_waddr !== 5'd7) begin err_count++; $display("FAIL basic_waddr: got %0h want 7", vtx_instr_waddr); end
        cmp_count++; if (vtx_instr_wdata !== 32'hA5) begin err_count++; $display("FAIL basic_wdata: got %0h want a5", vtx_instr_wdata); end
        exp_cprs = '0; exp_cprs[0 +: 32] = 32'hDEAD;
        cmp_count++; if (vtx_cprs_pre !== exp_cprs) begin err_count++; $display("FAIL basic_pre: got cpr3=%0h cpr0=%0h want cpr3=0 cpr0=dead", vtx_cprs_pre[96 +: 32], vtx_cprs_pre[0 +: 32]); end
        exp_cprs[96 +: 32] = 32'd9;
        cmp_count++; if (vtx_cprs_post !== exp_cprs) begin err_count++; $display("FAIL basic_post: got cpr3=%0h cpr0=%0h want cpr3=9 cpr0=dead", vtx_cprs_post[96 +: 32], vtx_cprs_post[0 +: 32]); end
        cmp_count++; if (vtx_mem_cen !== 4'h0) begin err_count++; $display("FAIL basic_mem_cen: got %0h want 0", vtx_mem_cen); end
        step;
        cmp_count++; if (vtx_valid !== 1'b0) begin err_count++; $display("FAIL basic_valid_drop: got %0h want 0", vtx_valid); end
        cmp_count++; if (vtx_instr_enc !== 32'h1234) begin err_count++; $display("FAIL basic_hold: got %0h want 1234", vtx_instr_enc); end
    endtask

    task automatic test_mem_slots;
        do_accept(32'h0000_0100, 32'd0, 32'd0);
        do_txn(1'b0, 32'h100, 32'h0, 4'hF, 32'h11, 1'b0, 2);
        do_txn(1'b0, 32'h104, 32'h0, 4'hF, 32'h22, 1'b0, 0);
        do_retire(3'd1, 1'b0, 5'd0, 32'd0);
        step;
        cmp_count++; if (vtx_valid !== 1'b1) begin err_count++; $display("FAIL mem_valid: got %0h want 1", vtx_valid); end
        cmp_count++; if (vtx_mem_cen !== 4'b0011) begin err_count++; $display("FAIL mem_cen: got %0h want 3", vtx_mem_cen); end
        cmp_count++; if (vtx_mem_wen !== 4'b0000) begin err_count++; $display("FAIL mem_wen: got %0h want 0", vtx_mem_wen); end
        cmp_count++; if (vtx_mem_addr[63:0] !== 64'h0000_0104_0000_0100) begin err_count++; $display("FAIL mem_addr: got %0h want 10400000100", vtx_mem_addr[63:0]); end
        cmp_count++; if (vtx_mem_rdata[63:0] !== 64'h0000_0022_0000_0011) begin err_count++; $display("FAIL mem_rdata: got %0h want 2200000011", vtx_mem_rdata[63:0]); end
        cmp_count++; if (vtx_mem_error !== 4'b0000) begin err_count++; $display("FAIL mem_error: got %0h want 0", vtx_mem_error); end
        cmp_count++; if (vtx_mem_ovf !== 1'b0) begin err_count++; $display("FAIL mem_ovf: got %0h want 0", vtx_mem_ovf); end
        cmp_count++; if (vtx_instr_result !== 3'd1) begin err_count++; $display("FAIL mem_result: got %0h want 1", vtx_instr_result); end
        step;
    endtask

    task automatic test_overflow;
        do_accept(32'h0000_0200, 32'd0, 32'd0);
        do_txn(1'b1, 32'h200, 32'd1, 4'h1, 32'd0, 1'b0, 0);
        do_txn(1'b1, 32'h204, 32'd2, 4'h3, 32'd0, 1'b0, 1);
        do_txn(1'b1, 32'h208, 32'd3, 4'h7, 32'd0, 1'b1, 0);
        do_txn(1'b1, 32'h20C, 32'd4, 4'hF, 32'd0, 1'b0, 0);
        do_txn(1'b1, 32'h210, 32'd5, 4'h8, 32'd0, 1'b1, 0);
        do_retire(3'd0, 1'b0, 5'd0, 32'd0);
        step;
        cmp_count++; if (vtx_valid !== 1'b1) begin err_count++; $display("FAIL ovf_valid: got %0h want 1", vtx_valid); end
        cmp_count++; if (vtx_mem_cen !== 4'b1111) begin err_count++; $display("FAIL ovf_cen: got %0h want f", vtx_mem_cen); end
        cmp_count++; if (vtx_mem_wen !== 4'b1111) begin err_count++; $display("FAIL ovf_wen: got %0h want f", vtx_mem_wen); end
        cmp_count++; if (vtx_mem_addr !== 128'h0000_020C_0000_0208_0000_0204_0000_0200) begin err_count++; $display("FAIL ovf_addr: got %0h want 20c00000208000002040000 0200", vtx_mem_addr); end
        cmp_count++; if (vtx_mem_wdata !== 128'h0000_0004_0000_0003_0000_0002_0000_0001) begin err_count++; $display("FAIL ovf_wdata: got %0h want 4/3/2/1", vtx_mem_wdata); end
        cmp_count++; if (vtx_mem_ben !== 16'hF731) begin err_count++; $display("FAIL ovf_ben: got %0h want f731", vtx_mem_ben); end
        cmp_count++; if (vtx_mem_error !== 4'b0100) begin err_count++; $display("FAIL ovf_error: got %0h want 4", vtx_mem_error); end
        cmp_count++; if (vtx_mem_ovf !== 1'b1) begin err_count++; $display("FAIL ovf_flag: got %0h want 1", vtx_mem_ovf); end
        step;
    endtask

    task automatic test_back_to_back;
        cop_cprs = '0; cop_cprs[32 +: 32] = 32'h55;
        do_accept(32'h0000_000A, 32'd1, 32'd0);
        do_txn(1'b0, 32'h400, 32'd0, 4'hF, 32'h44, 1'b0, 0);
        cop_cprs[32 +: 32] = 32'h77;
        do_retire(3'd0, 1'b1, 5'd1, 32'hA);
        do_accept(32'h0000_000B, 32'd2, 32'd0);
        cmp_count++; if (vtx_valid !== 1'b1) begin err_count++; $display("FAIL b2b_a_valid: got %0h want 1", vtx_valid); end
        cmp_count++; if (vtx_instr_enc !== 32'hA) begin err_count++; $display("FAIL b2b_a_enc: got %0h want a", vtx_instr_enc); end
        cmp_count++; if (vtx_mem_cen !== 4'b0001) begin err_count++; $display("FAIL b2b_a_cen: got %0h want 1", vtx_mem_cen); end
        cmp_count++; if (vtx_mem_addr[31:0] !== 32'h400) begin err_count++; $display("FAIL b2b_a_addr: got %0h want 400", vtx_mem_addr[31:0]); end
        cmp_count++; if (vtx_cprs_post[32 +: 32] !== 32'h77) begin err_count++; $display("FAIL b2b_a_post: got %0h want 77", vtx_cprs_post[32 +: 32]); end
        cmp_count++; if (vtx_cprs_pre[32 +: 32] !== 32'h55) begin err_count++; $display("FAIL b2b_a_pre: got %0h want 55", vtx_cprs_pre[32 +: 32]); end
        cop_cprs[32 +: 32] = 32'h88;
        do_retire(3'd2, 1'b0, 5'd0, 32'd0);
        cmp_count++; if (vtx_valid !== 1'b0) begin err_count++; $display("FAIL b2b_gap: got %0h want 0", vtx_valid); end
        step;
        cmp_count++; if (vtx_valid !== 1'b1) begin err_count++; $display("FAIL b2b_b_valid: got %0h want 1", vtx_valid); end
        cmp_count++; if (vtx_instr_enc !== 32'hB) begin err_count++; $display("FAIL b2b_b_enc: got %0h want b", vtx_instr_enc); end
        cmp_count++; if (vtx_cprs_pre[32 +: 32] !== 32'h77) begin err_count++; $display("FAIL b2b_b_pre: got %0h want 77", vtx_cprs_pre[32 +: 32]); end
        cmp_count++; if (vtx_cprs_post[32 +: 32] !== 32'h88) begin err_count++; $display("FAIL b2b_b_post: got %0h want 88", vtx_cprs_post[32 +: 32]); end
        cmp_count++; if (vtx_mem_cen !== 4'b0000) begin err_count++; $display("FAIL b2b_b_cen: got %0h want 0", vtx_mem_cen); end
        cmp_count++; if (vtx_instr_result !== 3'd2) begin err_count++; $display("FAIL b2b_b_result: got %0h want 2", vtx_instr_result); end
        step;
    endtask

    task automatic test_reset_mid;
        do_accept(32'h0000_000C, 32'd3, 32'd0);
        do_txn(1'b0, 32'h500, 32'd0, 4'hF, 32'h1, 1'b0, 0);
        do_txn(1'b0, 32'h504, 32'd0, 4'hF, 32'h2, 1'b0, 0);
        cmp_count++; if (vtx_reset !== 1'b0) begin err_count++; $display("FAIL mid_pre_reset: got %0h want 0", vtx_reset); end
        g_resetn = 0;
        step;
        cmp_count++; if (vtx_reset !== 1'b1) begin err_count++; $display("FAIL mid_reset_1: got %0h want 1", vtx_reset); end
        cmp_count++; if (vtx_instr_enc !== 32'h0) begin err_count++; $display("FAIL mid_enc_clr: got %0h want 0", vtx_instr_enc); end
        step;
        cmp_count++; if (vtx_reset !== 1'b1) begin err_count++; $display("FAIL mid_reset_2: got %0h want 1", vtx_reset); end
        g_resetn = 1;
        step;
        cmp_count++; if (vtx_reset !== 1'b0) begin err_count++; $display("FAIL mid_reset_end: got %0h want 0", vtx_reset); end
        do_retire(3'd0, 1'b0, 5'd0, 32'd0);
        step;
        cmp_count++; if (vtx_valid !== 1'b0) begin err_count++; $display("FAIL mid_aborted_valid: got %0h want 0", vtx_valid); end
        do_accept(32'h0000_000D, 32'd4, 32'd0);
        do_txn(1'b0, 32'h300, 32'd0, 4'hF, 32'h33, 1'b0, 0);
        do_retire(3'd0, 1'b0, 5'd0, 32'd0);
        step;
        cmp_count++; if (vtx_valid !== 1'b1) begin err_count++; $display("FAIL mid_new_valid: got %0h want 1", vtx_valid); end
        cmp_count++; if (vtx_instr_enc !== 32'hD) begin err_count++; $display("FAIL mid_new_enc: got %0h want d", vtx_instr_enc); end
        cmp_count++; if (vtx_mem_cen !== 4'b0001) begin err_count++; $display("FAIL mid_new_cen: got %0h want 1", vtx_mem_cen); end
        cmp_count++; if (vtx_mem_addr[31:0] !== 32'h300) begin err_count++; $display("FAIL mid_new_addr: got %0h want 300", vtx_mem_addr[31:0]); end
        cmp_count++; if (vtx_mem_rdata[31:0] !== 32'h33) begin err_count++; $display("FAIL mid_new_rdata: got %0h want 33", vtx_mem_rdata[31:0]); end
        cmp_count++; if (vtx_mem_ovf !== 1'b0) begin err_count++; $display("FAIL mid_new_ovf: got %0h want 0", vtx_mem_ovf); end
        step;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_mem_slots;
        test_overflow;
        test_back_to_back;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end
endmodule
